if_stage: RTL and testbench

- Instruction-fetch stage: holds the program counter and fetches from instruction memory over a req/ack handshake.
- Presents {PC+4, instruction} to the IF/ID pipeline register, which samples whenever freeze is low.
- Emits a NOP bubble (PC 0, instruction 0) while a fetch is still outstanding.
- Handles taken branches, including a redirect that arrives while a fetch is in flight.

---
 rtl/if_stage.sv | 116 +++++++++++
 tb/tb_if_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// presents {PC+4, instruction} or an all-zero bubble to the IF/ID register.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branchTaken,
    input  logic [31:0] branchAddr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCout,
    output logic [31:0] instOut,
    output logic        instValid
);

    // state  | meaning
    // S_IDLE | one dead cycle after reset, no request
    // S_REQ  | request outstanding at pc, waiting for ack
    // S_HAVE | fetched word parked in inst_buf while downstream is frozen
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HAVE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [31:0] pc_next;

    assign pc_next = pc_q + PC_INC;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            inst_buf_q    <= 32'd0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inst_buf_q    <= inst_buf_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inst_buf_d    = inst_buf_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        imem_req      = 1'b0;
        imem_addr     = pc_q;
        instValid     = 1'b0;
        PCout         = 32'd0;
        instOut       = 32'd0;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (pend_valid_q || branchTaken) begin
                        // Word belongs to the wrong path: drop it and refetch.
                        pc_d         = branchTaken ? branchAddr : pend_target_q;
                        pend_valid_d = 1'b0;
                    end else begin
                        instValid = 1'b1;
                        instOut   = imem_rdata;
                        PCout     = pc_next;
                        if (freeze) begin
                            inst_buf_d = imem_rdata;
                            state_d    = S_HAVE;
                        end else begin
                            pc_d = pc_next;
                        end
                    end
                end else if (branchTaken) begin
                    pend_valid_d  = 1'b1;
                    pend_target_d = branchAddr;
                end
            end

            S_HAVE: begin
                instValid = 1'b1;
                instOut   = inst_buf_q;
                PCout     = pc_next;
                if (branchTaken) begin
                    pc_d    = branchAddr;
                    state_d = S_REQ;
                end else if (!freeze) begin
                    pc_d    = pc_next;
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with literal expectations, then
// randomized freeze/branch/ack traffic checked against a behavioural model.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branchTaken;
    logic [31:0] branchAddr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PCout;
    logic [31:0] instOut;
    logic        instValid;

    int n_vec = 0;
    int n_err = 0;

    // behavioural model: where the fetch stands, abstractly
    bit          m_first;
    bit          m_holding;
    logic [31:0] m_held;
    logic [31:0] m_pc;
    bit          m_redirect;
    logic [31:0] m_redirect_to;

    // DUT outputs as sampled in the most recent step
    logic        s_req, s_val;
    logic [31:0] s_addr, s_pc, s_inst;

    if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .branchTaken (branchTaken),
        .branchAddr  (branchAddr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .PCout       (PCout),
        .instOut     (instOut),
        .instValid   (instValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'd8) return 32'h2002_0005;
        return {a[15:0], ~a[31:16]} ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input bit f, input bit b, input logic [31:0] ba, input bit a);
        bit          e_req, e_val;
        logic [31:0] e_pc, e_inst;
        @(negedge clk);
        freeze      = f;
        branchTaken = b;
        branchAddr  = ba;
        imem_ack    = a;
        imem_rdata  = a ? memfn(imem_addr) : $urandom;
        #1;
        e_req = 0; e_val = 0; e_pc = 0; e_inst = 0;
        if (m_first) begin
            e_req = 0;
        end else if (m_holding) begin
            e_val  = 1;
            e_pc   = m_pc + 32'd4;
            e_inst = m_held;
        end else begin
            e_req = 1;
            if (a && !m_redirect && !b) begin
                e_val  = 1;
                e_pc   = m_pc + 32'd4;
                e_inst = memfn(m_pc);
            end
        end
        s_req = imem_req; s_val = instValid; s_addr = imem_addr;
        s_pc = PCout; s_inst = instOut;
        chk("imem_req", 32'(imem_req), 32'(e_req));
        chk("instValid", 32'(instValid), 32'(e_val));
        chk("PCout", PCout, e_pc);
        chk("instOut", instOut, e_inst);
        if (e_req) chk("imem_addr", imem_addr, m_pc);
        @(posedge clk);
        if (m_first) begin
            m_first = 0;
        end else if (m_holding) begin
            if (b) begin
                m_pc = ba; m_holding = 0;
            end else if (!f) begin
                m_pc = m_pc + 32'd4; m_holding = 0;
            end
        end else if (a) begin
            if (m_redirect || b) begin
                m_pc = b ? ba : m_redirect_to;
                m_redirect = 0;
            end else if (f) begin
                m_held = memfn(m_pc); m_holding = 1;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end else if (b) begin
            m_redirect = 1; m_redirect_to = ba;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instValid), 32'd0);
        chk("rst_pcout", PCout, 32'd0);
        chk("rst_inst", instOut, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        m_first = 1; m_holding = 0; m_held = 0; m_pc = 32'd0;
        m_redirect = 0; m_redirect_to = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; freeze = 0; branchTaken = 0; branchAddr = 0;
        imem_ack = 0; imem_rdata = 0;

        // zero-wait memory
        do_reset();
        step(0, 0, 0, 1);
        chk("idle_req", 32'(s_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1);
            chk("zw_pcout", s_pc, 32'(4 * (i + 1)));
            chk("zw_valid", 32'(s_val), 32'd1);
        end

        // two-cycle ack latency
        do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("lat_addr0", s_addr, 32'd0);
        chk("lat_bubble0", 32'(s_val), 32'd0);
        step(0, 0, 0, 0);
        chk("lat_addr1", s_addr, 32'd0);
        chk("lat_bubble1", s_pc, 32'd0);
        step(0, 0, 0, 1);
        chk("lat_addr2", s_addr, 32'd0);
        chk("lat_pcout", s_pc, 32'd4);

        // freeze for three cycles on the word at pc=8
        step(0, 0, 0, 1);
        chk("frz_pre", s_pc, 32'd8);
        step(1, 0, 0, 1);
        chk("frz_pc0", s_pc, 32'd12);
        chk("frz_inst0", s_inst, 32'h2002_0005);
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 0);
            chk("frz_pc", s_pc, 32'd12);
            chk("frz_inst", s_inst, 32'h2002_0005);
            chk("frz_req", 32'(s_req), 32'd0);
        end
        step(0, 0, 0, 0);
        chk("frz_rel_pc", s_pc, 32'd12);
        step(0, 0, 0, 0);
        chk("frz_next_addr", s_addr, 32'd12);

        // redirect during a three-cycle fetch
        step(0, 1, 32'h40, 0);
        step(0, 0, 0, 1);
        chk("br_drop_valid", 32'(s_val), 32'd0);
        chk("br_drop_pc", s_pc, 32'd0);
        step(0, 0, 0, 0);
        chk("br_addr", s_addr, 32'h40);
        step(0, 0, 0, 1);
        chk("br_pcout", s_pc, 32'h44);

        // branch beats freeze in the holding state
        step(1, 0, 0, 1);
        step(1, 1, 32'h100, 0);
        chk("hb_pcout", s_pc, 32'h48);
        chk("hb_req", 32'(s_req), 32'd0);
        step(0, 0, 0, 0);
        chk("hb_addr", s_addr, 32'h100);

        // wrap at the top of the address space
        step(0, 1, 32'hFFFF_FFFC, 1);
        chk("wrap_drop", 32'(s_val), 32'd0);
        step(0, 0, 0, 1);
        chk("wrap_pcout", s_pc, 32'd0);
        chk("wrap_valid", 32'(s_val), 32'd1);
        step(0, 0, 0, 0);
        chk("wrap_addr", s_addr, 32'd0);
        chk("wrap_req", 32'(s_req), 32'd1);

        // reset while a request is outstanding
        do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("rst_restart_addr", s_addr, 32'd0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit          f, b, a;
            logic [31:0] ba;
            if ($urandom_range(0, 299) == 0) do_reset();
            f  = ($urandom_range(0, 9) < 3);
            b  = ($urandom_range(0, 9) == 0);
            a  = ($urandom_range(0, 9) < 6);
            ba = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            step(f, b, ba, a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
